reg_file_param: RTL and testbench
=================================

Name: reg_file_param

Overview:
Parametrised next-generation register file for the 16-bit RISC core. It has a configurable data width, register count and number of registered read ports, plus one write port. Compared with the current register file it adds:
- optional write-to-read bypass
- an optional hardwired-zero register R0
- a per-register pending (scoreboard) bit for hazard detection
- a sequenced clear sweep driven by a small state machine

It sits between decode (read/reserve addresses) and writeback (write port).

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers
NUM_RD, 2, number of read ports
BYPASS, 1, 1 = a same-cycle write to a read address is forwarded to rd_data
ZERO_REG, 0, 1 = register 0 always reads 0, ignores writes, never pending

Ports:
clk  in  1  single clock; all state updates on posedge
rst  in  1  synchronous, active-low reset, sampled on posedge clk
rd_en  in  NUM_RD  per-port read enable
rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i = bits [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed registered read data; port i = bits [i*DATA_W +: DATA_W]
wr_en  in  1  write enable
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
rsv_en  in  1  reserve request: mark destination as pending
rsv_addr  in  ADDR_W  register to reserve
pend  out  DEPTH  per-register pending bits (registered)
clr  in  1  start clear sweep
clr_busy  out  1  high while the sweep runs

Behaviour:
- Reset (rst=0 at posedge):
  - all registers = 0, rd_data = 0, pend = 0
  - FSM = IDLE, clr_busy = 0, sweep counter = 0
  - rst overrides every other input, including mid-sweep.
- Read latency is 1 cycle.
  - If rd_en[i]=1 at a posedge, rd_data[i] is loaded with the value selected for rd_addr[i].
  - If rd_en[i]=0, rd_data[i] holds its value.
- Read value selection, highest priority first:
  - ZERO_REG=1 and address 0 -> 0
  - BYPASS=1, FSM=IDLE, wr_en=1 and wr_addr==rd_addr[i] -> wr_data
  - otherwise the stored register contents (pre-write value)
- Ports are independent; any ports may read the same address.
- Write:
  - In IDLE, wr_en=1 stores wr_data into wr_addr at the posedge.
  - Writes to address 0 are dropped when ZERO_REG=1.
  - In CLEAR, wr_en is ignored.
- Scoreboard, IDLE only, per register a:
  - set pend[a] when rsv_en=1 and rsv_addr==a
  - else clear pend[a] when wr_en=1 and wr_addr==a
  - Reserve and write to the same address in the same cycle -> pend stays/becomes 1 (newer producer wins).
  - Writes to a non-pending register are legal and leave pend=0.
  - ZERO_REG=1: pend[0] is always 0.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when clr=1. At that posedge: counter = 0, pend = all 0, clr_busy = 1 from the next cycle.
  - CLEAR, each cycle: register[counter] = 0, counter++.
  - When counter==DEPTH-1, that register is cleared and FSM -> IDLE; clr_busy goes low the following cycle.
  - Result: clr_busy is high for exactly DEPTH cycles.
  - clr, rsv_en and wr_en are ignored in CLEAR; pend stays 0.
  - Reads in CLEAR are allowed and return current contents with no bypass, so already-swept registers read 0.
- Counter wrap: the counter is ADDR_W bits and is never used past DEPTH-1.
- No X on outputs after reset; all state is synchronous.

Decomposition:
- Shared package: FSM state encoding (ST_IDLE=0, ST_CLEAR=1) and default width/depth constants (DATA_W=16, ADDR_W=4), shared with decode/writeback.
- One natural sub-module, reg_file_rd_port: single registered read port implementing the zero/bypass/storage mux. Instantiate it NUM_RD times with a generate loop.
- Storage array, scoreboard and clear FSM stay in the top module.

Test Plan:
- Reset, then read R3 on ports 0 and 1 -> both rd_data = 0x0000 one cycle later; pend = 0; clr_busy = 0.
- Write R5=0xBEEF; next cycle read R5 on port 0 -> 0xBEEF after 1 cycle. Hold rd_en=0 and write R5=0x1234 -> rd_data stays 0xBEEF.
- Bypass:
  - BYPASS=1: write R7=0xA5A5 and read R7 in the same cycle -> rd_data = 0xA5A5.
  - BYPASS=0: same stimulus -> old value 0x0000.
- ZERO_REG=1: write R0=0xFFFF, then read R0 -> 0x0000; rsv_en at R0 -> pend[0] = 0.
- Scoreboard:
  - rsv R9 -> pend[9] = 1 next cycle.
  - Write R9 -> pend[9] = 0.
  - Same-cycle rsv+write R9 -> pend[9] = 1.
- Clear sweep and reset mid-sweep:
  - Fill all 16 registers with nonzero values and assert clr -> clr_busy high exactly 16 cycles; a wr_en to R2 during the sweep is ignored; afterwards all reads are 0.
  - Repeat the sweep and assert rst=0 at cycle 5 -> FSM IDLE, clr_busy = 0, all registers 0.

Source files
------------

// File: rtl/reg_file_param_pkg.sv
// Shared definitions for the parametrised register file.
// Imported by the register file, decode and writeback.
package reg_file_param_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam int RF_DATA_W = 16;
  localparam int RF_ADDR_W = 4;

endpackage

// File: rtl/reg_file_param_if.sv
// Register file bus: read, write, reserve and clear.
// Master sits on the decode/writeback side; slave is the file.
interface reg_file_param_if
  import reg_file_param_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_RD = 2
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic [DEPTH-1:0]         pend;
  logic                     clr;
  logic                     clr_busy;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output rsv_en, rsv_addr, clr,
    input  rd_data, pend, clr_busy
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  rsv_en, rsv_addr, clr,
    output rd_data, pend, clr_busy
  );

endinterface

// File: rtl/reg_file_param_rd_port.sv
// One registered read port: zero / bypass / storage select.
// The caller supplies the already-indexed storage word.
module reg_file_rd_port #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_mem,
  input  logic              i_byp,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0] o_data
);

  logic              w_zero;
  logic              w_hit;
  logic [DATA_W-1:0] w_sel;
  logic [DATA_W-1:0] r_data;

  assign w_zero = (ZERO_REG != 0) && (i_addr == '0);
  assign w_hit  = (BYPASS != 0) && i_byp &&
                  (i_wr_addr == i_addr) && !w_zero;

  // Pick the value to load: R0 zero, then bypass, then storage.
  always_comb begin
    w_sel = i_mem;
    unique case (1'b1)
      w_zero:  w_sel = '0;
      w_hit:   w_sel = i_wr_data;
      default: w_sel = i_mem;
    endcase
  end

  // Load on enable, hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst)
      r_data <= '0;
    else if (i_en)
      r_data <= w_sel;
  end

  assign o_data = r_data;

endmodule

// File: rtl/reg_file_param.sv
// Parametrised register file with scoreboard and clear sweep.
// Storage, pending bits and sweep FSM live here.
module reg_file_param
  import reg_file_param_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input logic clk,
  input logic rst,
  reg_file_param_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_busy;
  logic [DEPTH-1:0]  r_pend;

  logic              w_idle;
  logic              w_wr;
  logic [DEPTH-1:0]  w_pend_nxt;
  logic [DATA_W-1:0] w_rd [NUM_RD];

  assign w_idle = (r_state == ST_IDLE);
  assign w_wr   = w_idle && bus.wr_en &&
                  !((ZERO_REG != 0) && (bus.wr_addr == '0));

  // Next pending bits: a reserve beats a same-cycle write.
  always_comb begin
    w_pend_nxt = r_pend;
    for (int a = 0; a < DEPTH; a++) begin
      if (bus.rsv_en && bus.rsv_addr == ADDR_W'(a))
        w_pend_nxt[a] = 1'b1;
      else if (bus.wr_en && bus.wr_addr == ADDR_W'(a))
        w_pend_nxt[a] = 1'b0;
    end
    if (ZERO_REG != 0)
      w_pend_nxt[0] = 1'b0;
  end

  // Storage: reset, sweep one word per cycle, or write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int a = 0; a < DEPTH; a++)
        r_mem[a] <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr) begin
      r_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Sweep FSM and scoreboard; pend frozen at 0 while clearing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_pend  <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.clr) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_pend  <= '0;
          end else begin
            r_pend  <= w_pend_nxt;
          end
        end
        ST_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    reg_file_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG)
    ) u_rd (
      .clk       (clk),
      .rst       (rst),
      .i_en      (bus.rd_en[i]),
      .i_addr    (bus.rd_addr[i*ADDR_W +: ADDR_W]),
      .i_mem     (r_mem[bus.rd_addr[i*ADDR_W +: ADDR_W]]),
      .i_byp     (w_idle && bus.wr_en),
      .i_wr_addr (bus.wr_addr),
      .i_wr_data (bus.wr_data),
      .o_data    (w_rd[i])
    );
  end

  // Pack the per-port read data onto the bus.
  always_comb begin
    bus.rd_data = '0;
    for (int i = 0; i < NUM_RD; i++)
      bus.rd_data[i*DATA_W +: DATA_W] = w_rd[i];
  end

  assign bus.pend     = r_pend;
  assign bus.clr_busy = r_busy;

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench: A = bypass, B = no bypass, C = bypass + zero R0.
// All three share the same stimulus.
module tb_reg_file_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rd_en;
  logic [7:0]  rd_addr;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        rsv_en;
  logic [3:0]  rsv_addr;
  logic        clr;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  reg_file_param_if #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2)) ifa ();
  reg_file_param_if #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2)) ifb ();
  reg_file_param_if #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2)) ifc ();

  assign ifa.rd_en = rd_en;    assign ifb.rd_en = rd_en;
  assign ifc.rd_en = rd_en;
  assign ifa.rd_addr = rd_addr; assign ifb.rd_addr = rd_addr;
  assign ifc.rd_addr = rd_addr;
  assign ifa.wr_en = wr_en;    assign ifb.wr_en = wr_en;
  assign ifc.wr_en = wr_en;
  assign ifa.wr_addr = wr_addr; assign ifb.wr_addr = wr_addr;
  assign ifc.wr_addr = wr_addr;
  assign ifa.wr_data = wr_data; assign ifb.wr_data = wr_data;
  assign ifc.wr_data = wr_data;
  assign ifa.rsv_en = rsv_en;  assign ifb.rsv_en = rsv_en;
  assign ifc.rsv_en = rsv_en;
  assign ifa.rsv_addr = rsv_addr; assign ifb.rsv_addr = rsv_addr;
  assign ifc.rsv_addr = rsv_addr;
  assign ifa.clr = clr;        assign ifb.clr = clr;
  assign ifc.clr = clr;

  reg_file_param #(
    .DATA_W(16), .ADDR_W(4), .NUM_RD(2), .BYPASS(1), .ZERO_REG(0)
  ) dut_a (.clk(clk), .rst(rst), .bus(ifa));

  reg_file_param #(
    .DATA_W(16), .ADDR_W(4), .NUM_RD(2), .BYPASS(0), .ZERO_REG(0)
  ) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  reg_file_param #(
    .DATA_W(16), .ADDR_W(4), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1)
  ) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    rd_en = '0; rd_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; clr = 1'b0;
  endtask

  task automatic fill_all();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = 16'h1000 + 16'(i);
      cyc();
    end
    wr_en = 1'b0;
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < 8; i++) begin
      rd_en = 2'b11;
      rd_addr = {4'(2*i + 1), 4'(2*i)};
      cyc();
      chk(tag, 32'(ifa.rd_data), 32'h0);
    end
    rd_en = 2'b00;
  endtask

  initial begin
    idle_in();
    rst = 1'b0;
    cyc(); cyc();
    rst = 1'b1;

    chk("rst_rd", 32'(ifa.rd_data), 32'h0);
    chk("rst_pend", 32'(ifa.pend), 32'h0);
    chk("rst_busy", 32'(ifa.clr_busy), 32'h0);

    rd_en = 2'b11; rd_addr = {4'd3, 4'd3};
    cyc();
    chk("r3_both", 32'(ifa.rd_data), 32'h0);

    rd_en = 2'b00;
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF;
    cyc();
    wr_en = 1'b0; rd_en = 2'b01; rd_addr = {4'd0, 4'd5};
    cyc();
    chk("r5_read", 32'(ifa.rd_data[15:0]), 32'hBEEF);
    rd_en = 2'b00;
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h1234;
    cyc();
    chk("r5_hold", 32'(ifa.rd_data[15:0]), 32'hBEEF);
    wr_en = 1'b0; rd_en = 2'b10; rd_addr = {4'd5, 4'd0};
    cyc();
    chk("r5_new_p1", 32'(ifa.rd_data[31:16]), 32'h1234);
    chk("r5_p0_hold", 32'(ifa.rd_data[15:0]), 32'hBEEF);

    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'hA5A5;
    rd_en = 2'b01; rd_addr = {4'd0, 4'd7};
    cyc();
    chk("byp_on", 32'(ifa.rd_data[15:0]), 32'hA5A5);
    chk("byp_off", 32'(ifb.rd_data[15:0]), 32'h0000);
    wr_en = 1'b0;
    cyc();
    chk("byp_off_late", 32'(ifb.rd_data[15:0]), 32'hA5A5);

    rd_en = 2'b00;
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF;
    cyc();
    wr_en = 1'b0; rd_en = 2'b10; rd_addr = {4'd0, 4'd0};
    cyc();
    chk("zr_read", 32'(ifc.rd_data[31:16]), 32'h0);
    chk("r0_plain", 32'(ifa.rd_data[31:16]), 32'hFFFF);
    rd_en = 2'b00;
    rsv_en = 1'b1; rsv_addr = 4'd0;
    cyc();
    chk("zr_pend0", 32'(ifc.pend[0]), 32'h0);
    chk("r0_pend0", 32'(ifa.pend[0]), 32'h1);

    rsv_addr = 4'd9;
    cyc();
    chk("rsv9", 32'(ifa.pend[9]), 32'h1);
    chk("rsv9_pend", 32'(ifa.pend), 32'h0201);
    rsv_en = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'h0009;
    cyc();
    chk("wr9", 32'(ifa.pend[9]), 32'h0);
    rsv_en = 1'b1; rsv_addr = 4'd9;
    cyc();
    chk("rsvwr9", 32'(ifa.pend[9]), 32'h1);
    chk("rsvwr9_c", 32'(ifc.pend), 32'h0200);
    idle_in();

    fill_all();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("clr_pend", 32'(ifa.pend), 32'h0);
    n = 0;
    while (ifa.clr_busy === 1'b1 && n < 40) begin
      n++;
      wr_en = (n == 5);
      wr_addr = 4'd2; wr_data = 16'h7777;
      rsv_en = (n == 7); rsv_addr = 4'd4;
      cyc();
      if (n == 7)
        chk("clr_rsv", 32'(ifa.pend), 32'h0);
    end
    idle_in();
    chk("busy_len", 32'(n), 32'd16);
    chk("busy_c", 32'(ifc.clr_busy), 32'h0);
    read_all_zero("sweep_rd");
    chk("post_pend", 32'(ifa.pend), 32'h0);

    fill_all();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    chk("mid_busy", 32'(ifa.clr_busy), 32'h1);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    chk("mrst_busy", 32'(ifa.clr_busy), 32'h0);
    chk("mrst_rd", 32'(ifa.rd_data), 32'h0);
    read_all_zero("mrst_rd");

    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 16'h4242;
    cyc();
    wr_en = 1'b0; rd_en = 2'b01; rd_addr = {4'd0, 4'd1};
    cyc();
    chk("mrst_idle_wr", 32'(ifa.rd_data[15:0]), 32'h4242);
    idle_in();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
